// File: rtl/tour_cmd.sv
// tour_cmd: passes UART commands through to cmd_proc, and during a knight's tour splits each
// one-hot L-move into a vertical leg then a horizontal leg, handshaked with cmd_proc.
module tour_cmd #(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);
  typedef enum logic [2:0] {IDLE, VERT, VERT_WAIT, HORZ, HORZ_WAIT} state_t;
  localparam logic [7:0] N = 8'h00, W = 8'h3F, S = 8'h7F, E = 8'hBF;
  state_t state, nxt;
  logic [4:0] nxt_indx;
  logic [7:0] vh, hh;
  logic [1:0] vs, hs;
  logic tour, last;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state   <= IDLE;
      mv_indx <= '0;
    end else begin
      state   <= nxt;
      mv_indx <= nxt_indx;
    end
  // Lowest set bit wins when move is not one-hot.
  always_comb begin
    {vh, vs, hh, hs} = {N, 2'd2, W, 2'd1};
    priority casez (move)
      8'b???????1: {vh, vs, hh, hs} = {N, 2'd2, W, 2'd1};
      8'b??????10: {vh, vs, hh, hs} = {N, 2'd2, E, 2'd1};
      8'b?????100: {vh, vs, hh, hs} = {N, 2'd1, W, 2'd2};
      8'b????1000: {vh, vs, hh, hs} = {S, 2'd1, W, 2'd2};
      8'b???10000: {vh, vs, hh, hs} = {S, 2'd2, W, 2'd1};
      8'b??100000: {vh, vs, hh, hs} = {S, 2'd2, E, 2'd1};
      8'b?1000000: {vh, vs, hh, hs} = {S, 2'd1, E, 2'd2};
      8'b10000000: {vh, vs, hh, hs} = {N, 2'd1, E, 2'd2};
      default:     {vh, vs, hh, hs} = {N, 2'd2, W, 2'd1};
    endcase
  end
  assign last = mv_indx == 5'(NUM_MOVES - 1);
  always_comb begin
    nxt      = state;
    nxt_indx = mv_indx;
    case (state)
      IDLE:      nxt = start_tour ? VERT : IDLE;
      VERT:
        if (~|move) begin
          nxt      = IDLE;
          nxt_indx = '0;
        end else if (clr_cmd_rdy)
          nxt = VERT_WAIT;
      VERT_WAIT: nxt = send_resp ? HORZ : VERT_WAIT;
      HORZ:      nxt = clr_cmd_rdy ? HORZ_WAIT : HORZ;
      HORZ_WAIT:
        if (send_resp) begin
          nxt      = last ? IDLE : VERT;
          nxt_indx = last ? 5'd0 : mv_indx + 5'd1;
        end
      default: begin
        nxt      = IDLE;
        nxt_indx = '0;
      end
    endcase
  end
  assign tour             = state != IDLE;
  assign cmd              = !tour ? cmd_UART :
                            (state == VERT || state == VERT_WAIT) ? {4'h4, vh, 2'b00, vs} :
                            {4'h5, hh, 2'b00, hs};
  assign cmd_rdy          = !tour ? cmd_rdy_UART : (state == VERT && |move) || state == HORZ;
  assign clr_cmd_rdy_UART = !tour && clr_cmd_rdy;
  assign resp             = (tour && !(state == HORZ_WAIT && last)) ? 8'h5A : 8'hA5;
endmodule

// File: doc/tour_cmd.md
Name: tour_cmd

Overview:
- Command sequencer and source arbiter in front of cmd_proc.
- In UART mode it passes Bluetooth/UART commands straight through to cmd_proc.
- On tour_go from cmd_proc it takes ownership of the command port. It steps through the precomputed knight's-tour move list and splits each one-hot L-move into two single-axis move commands. Each leg is handshaked with cmd_proc's clr_cmd_rdy/send_resp.
- It generates the response byte returned over UART.

Parameters:
- NUM_MOVES, 24: number of knight moves in a tour; mv_indx runs 0..NUM_MOVES-1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- start_tour  input  1  tour_go pulse from cmd_proc
- move  input  8  one-hot knight move read from the tour store at mv_indx
- mv_indx  output  5  index of the current tour move
- cmd_UART  input  16  command from the UART wrapper
- cmd_rdy_UART  input  1  UART command valid
- clr_cmd_rdy_UART  output  1  clears the UART command-ready flag
- cmd  output  16  command to cmd_proc: [15:12] opcode, [11:4] heading, [3:0] squares
- cmd_rdy  output  1  command valid to cmd_proc
- clr_cmd_rdy  input  1  cmd_proc has accepted the command
- send_resp  input  1  cmd_proc has completed the command
- resp  output  8  response byte to the UART wrapper

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n). While rst_n=0 at a clk edge: state<=IDLE, mv_indx<=0.
  - Resulting outputs: cmd_rdy = cmd_rdy_UART (mux in UART mode), clr_cmd_rdy_UART=0 unless cmd_proc drives clr_cmd_rdy, resp=0xA5.
  - Reset mid-tour aborts the tour immediately; no further tour command is issued.
- States: IDLE, VERT, VERT_WAIT, HORZ, HORZ_WAIT.
- IDLE (UART mode):
  - cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy.
  - start_tour=1 -> VERT next cycle; mv_indx stays 0.
- Tour mode (all non-IDLE states):
  - cmd_rdy_UART is ignored and clr_cmd_rdy_UART=0.
  - start_tour is ignored.
  - cmd is decoded combinationally from move and state.
- VERT: cmd_rdy=1, cmd = vertical leg. clr_cmd_rdy=1 -> VERT_WAIT. send_resp while in VERT is ignored.
- VERT_WAIT: cmd_rdy=0, cmd held. send_resp=1 -> HORZ.
- HORZ: cmd_rdy=1, cmd = horizontal leg. clr_cmd_rdy=1 -> HORZ_WAIT.
- HORZ_WAIT: cmd_rdy=0. On send_resp=1:
  - if mv_indx==NUM_MOVES-1: mv_indx<=0, go to IDLE;
  - else mv_indx<=mv_indx+1, go to VERT.
- Leg opcodes: vertical leg 0x4 (move); horizontal leg 0x5 (move with fanfare).
- Headings (cmd[11:4]): N=0x00, W=0x3F, S=0x7F, E=0xBF.
- Move decode, vertical leg then horizontal leg:

  | move bit | vertical leg | horizontal leg |
  |---|---|---|
  | b0 | N2 | W1 |
  | b1 | N2 | E1 |
  | b2 | N1 | W2 |
  | b3 | S1 | W2 |
  | b4 | S2 | W1 |
  | b5 | S2 | E1 |
  | b6 | S1 | E2 |
  | b7 | N1 | E2 |

  - Squares go in cmd[3:0] (upper bit 0).
  - Non-one-hot move: the lowest set bit wins.
  - move==0 while in VERT: tour aborted, mv_indx<=0, go to IDLE; no command is issued.
- resp is combinational:
  - 0x5A while state!=IDLE and not (state==HORZ_WAIT and mv_indx==NUM_MOVES-1);
  - otherwise 0xA5 (UART commands and the final tour move).
- Latency:
  - start_tour at edge N -> cmd_rdy=1 from cycle N+1.
  - clr_cmd_rdy at edge M -> cmd_rdy=0 from M+1.
- Simultaneous clr_cmd_rdy and send_resp in VERT or HORZ: only clr_cmd_rdy takes effect; send_resp is dropped.
- mv_indx changes only on the HORZ_WAIT exit, so move is stable across both legs.

Test Plan:
- UART passthrough: in IDLE drive cmd_UART=0x4003, cmd_rdy_UART=1, then clr_cmd_rdy=1 -> cmd=0x4003, cmd_rdy=1, clr_cmd_rdy_UART=1 the same cycle; resp=0xA5.
- Single tour move: start_tour, move=0x01 -> cmd=0x4002, cmd_rdy=1 next cycle; after clr_cmd_rdy then send_resp -> cmd=0x53F1, cmd_rdy=1; after clr_cmd_rdy then send_resp -> mv_indx=1, resp=0x5A.
- Full tour, NUM_MOVES=24, all 8 move encodings cycled: 48 commands match the decode table; on the last send_resp -> resp=0xA5, state IDLE, mv_indx=0.
- In tour mode assert cmd_rdy_UART=1 with cmd_UART=0x2000 -> cmd unchanged, clr_cmd_rdy_UART=0; a second start_tour has no effect.
- send_resp pulsed in VERT before clr_cmd_rdy -> stays VERT, cmd_rdy=1.
- move=0x00 in VERT -> IDLE, mv_indx=0.
- rst_n=0 for one cycle while in HORZ_WAIT at mv_indx=10 -> IDLE, mv_indx=0, resp=0xA5; a following send_resp causes no change.
